// File: rtl/iccm_boot_pkg.sv
// Shared types and constants for the ICCM boot loader.
// Holds the word-FSM and UART-receiver state encodings and the minimum legal bit period.
package iccm_boot_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ASSEMBLE = 3'd1,
        WRITE    = 3'd2,
        CHECK    = 3'd3,
        DONE     = 3'd4,
        OVERFLOW = 3'd5
    } boot_state_e;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned MinClksPerBit = 4;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, idle high.
// Ports:
//   clock, reset     - system clock, asynchronous active-high reset
//   rx_i             - raw serial input (synchronised internally)
//   clks_per_bit_i   - bit period in clocks, captured at each start-bit detection
//   byte_valid_o     - one-cycle pulse, byte_o holds a received byte with a good stop bit
//   byte_o           - received byte
//   frame_err_o      - one-cycle pulse when the stop bit is sampled low (byte dropped)
module uart_rx_core
    import iccm_boot_pkg::*;
#(
    parameter int unsigned SyncStages = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_i,
    input  logic [15:0] clks_per_bit_i,
    output logic        byte_valid_o,
    output logic [7:0]  byte_o,
    output logic        frame_err_o
);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic                  rx_s;
    logic                  rx_prev_q, rx_prev_d;
    uart_state_e           state_q, state_d;
    logic [15:0]           cpb_q, cpb_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    assign rx_s         = sync_q[SyncStages-1];
    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
    assign frame_err_o  = ferr_q;

    always_comb begin
        sync_d    = {sync_q[SyncStages-2:0], rx_i};
        rx_prev_d = rx_s;
        state_d   = state_q;
        cpb_d     = cpb_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            U_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = U_START;
                    cnt_d   = '0;
                    // Illegal short periods are clamped so the half-bit count never underflows.
                    cpb_d   = (clks_per_bit_i < 16'(MinClksPerBit)) ? 16'(MinClksPerBit)
                                                                     : clks_per_bit_i;
                end
            end
            U_START: begin
                if (cnt_q == (cpb_q >> 1) - 16'd1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = rx_s ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            U_DATA: begin
                if (cnt_q == cpb_q - 16'd1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            U_STOP: begin
                if (cnt_q == cpb_q - 16'd1) begin
                    cnt_d   = '0;
                    state_d = U_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            state_q   <= U_IDLE;
            cpb_q     <= 16'(MinClksPerBit);
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cpb_q     <= cpb_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

endmodule

// File: rtl/iccm_boot_loader.sv
// UART-to-ICCM boot loader: packs received bytes little-endian into DataWidth words and writes
// them to consecutive ICCM word addresses, releasing the core once the terminating word arrives.
// Optional build macro ICCM_BOOT_CHECKSUM_EN: after the terminating word one more word is taken
// as the XOR of all written words; a mismatch leaves the core in reset and flags err_o.
// Ports:
//   clock, reset     - system clock, asynchronous active-high reset
//   rx_i             - UART serial input
//   clks_per_bit_i   - UART bit period in clocks
//   we_o/addr_o/wdata_o - ICCM write port (we_o is a one-cycle strobe)
//   core_reset_o     - holds the core in reset until a clean finish
//   done_o, err_o    - sticky status
module iccm_boot_loader
    import iccm_boot_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 12,
    parameter logic [63:0] EndWord    = 64'h0000_0000_0000_0FFF,
    parameter int unsigned SyncStages = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_i,
    input  logic [15:0]          clks_per_bit_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 core_reset_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned BytesPerWord = DataWidth / 8;
    localparam int unsigned IdxWidth     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
    localparam logic [IdxWidth-1:0]  LastIdx  = IdxWidth'(BytesPerWord - 1);
    localparam logic [DataWidth-1:0] EndWordW = EndWord[DataWidth-1:0];
    localparam logic [AddrWidth-1:0] LastAddr = {AddrWidth{1'b1}};

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_core #(
        .SyncStages(SyncStages)
    ) u_uart_rx_core (
        .clock         (clock),
        .reset         (reset),
        .rx_i          (rx_i),
        .clks_per_bit_i(clks_per_bit_i),
        .byte_valid_o  (rx_valid),
        .byte_o        (rx_byte),
        .frame_err_o   (rx_ferr)
    );

    boot_state_e          state_q, state_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [DataWidth-1:0] word_q, word_d, word_next;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    // addr_q is the next address to write; addr_out_q holds the last written one for addr_o.
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] addr_out_q, addr_out_d;
    logic                 full_q, full_d;
    logic                 core_rst_q, core_rst_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
`ifdef ICCM_BOOT_CHECKSUM_EN
    logic [DataWidth-1:0] xor_q, xor_d;
`endif

    assign we_o         = (state_q == WRITE);
    assign addr_o       = addr_out_q;
    assign wdata_o      = wdata_q;
    assign core_reset_o = core_rst_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

    always_comb begin
        word_next = word_q;
        word_next[{idx_q, 3'b000} +: 8] = rx_byte;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        addr_out_d = addr_out_q;
        full_d     = full_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef ICCM_BOOT_CHECKSUM_EN
        xor_d      = xor_q;
`endif
        case (state_q)
            IDLE, ASSEMBLE: begin
                if (rx_valid) begin
                    word_d  = word_next;
                    state_d = ASSEMBLE;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (word_next == EndWordW) begin
`ifdef ICCM_BOOT_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d    = DONE;
                            done_d     = 1'b1;
                            core_rst_d = 1'b0;
`endif
                        end else if (full_q) begin
                            state_d = OVERFLOW;
                            err_d   = 1'b1;
                        end else begin
                            state_d    = WRITE;
                            wdata_d    = word_next;
                            addr_out_d = addr_q;
                        end
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            WRITE: begin
                state_d = ASSEMBLE;
                // The top address is written once; afterwards only EndWord is accepted.
                if (addr_q == LastAddr) begin
                    full_d = 1'b1;
                end else begin
                    addr_d = addr_q + AddrWidth'(1);
                end
`ifdef ICCM_BOOT_CHECKSUM_EN
                xor_d = xor_q ^ wdata_q;
`endif
            end
`ifdef ICCM_BOOT_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    word_d = word_next;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (word_next == xor_q) begin
                            core_rst_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
`endif
            DONE, OVERFLOW: ;
            default: state_d = IDLE;
        endcase
        if (rx_ferr) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            addr_out_q <= '0;
            full_q     <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ICCM_BOOT_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            addr_out_q <= addr_out_d;
            full_q     <= full_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef ICCM_BOOT_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_iccm_boot_loader.sv
// Scoreboard bench for iccm_boot_loader with a 4-word ICCM (AddrWidth=2).
module tb_iccm_boot_loader;

    localparam int unsigned Depth = 4;
    localparam logic [31:0] End   = 32'h0000_0FFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] cpb = 16'd8;
    logic        we_o;
    logic [1:0]  addr_o;
    logic [31:0] wdata_o;
    logic        core_reset_o;
    logic        done_o;
    logic        err_o;

    iccm_boot_loader #(
        .DataWidth (32),
        .AddrWidth (2),
        .EndWord   (64'h0000_0000_0000_0FFF),
        .SyncStages(2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_i          (rx),
        .clks_per_bit_i(cpb),
        .we_o          (we_o),
        .addr_o        (addr_o),
        .wdata_o       (wdata_o),
        .core_reset_o  (core_reset_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    // Reference model state, at byte-stream / word-sequence level.
    int unsigned m_next_addr;
    logic [31:0] m_word;
    int unsigned m_cnt;
    logic [31:0] m_xor;
    logic        m_done, m_err, m_over, m_rel, m_check;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_next_addr = 0;
        m_word = '0;
        m_cnt = 0;
        m_xor = '0;
        m_done = 1'b0;
        m_err = 1'b0;
        m_over = 1'b0;
        m_rel = 1'b0;
        m_check = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_word(input logic [31:0] w);
        if (m_done || m_over) begin
            // terminal: ignored
        end else if (m_check) begin
            m_check = 1'b0;
            m_done = 1'b1;
            if (w == m_xor) m_rel = 1'b1;
            else m_err = 1'b1;
        end else if (w == End) begin
`ifdef ICCM_BOOT_CHECKSUM_EN
            m_check = 1'b1;
`else
            m_done = 1'b1;
            m_rel = 1'b1;
`endif
        end else if (m_next_addr == Depth) begin
            m_over = 1'b1;
            m_err = 1'b1;
        end else begin
            exp_q.push_back('{addr: m_next_addr, data: w});
            m_xor = m_xor ^ w;
            m_next_addr++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok) begin
            m_err = 1'b1;
        end else begin
            m_word[8*m_cnt +: 8] = b;
            m_cnt++;
            if (m_cnt == 4) begin
                model_word(m_word);
                m_cnt = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        logic [7:0] v;
        v = b;
        model_byte(b, stop_ok);
        rx = 1'b0;
        repeat (cpb) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            repeat (cpb) @(negedge clock);
        end
        rx = stop_ok;
        repeat (cpb) @(negedge clock);
        rx = 1'b1;
        repeat (cpb + 16'd2) @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic finish_prog(input logic good);
        send_word(End);
`ifdef ICCM_BOOT_CHECKSUM_EN
        send_word(good ? m_xor : ~m_xor);
`else
        if (!good) send_word(32'h0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        rx = 1'b1;
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_we", 64'(we_o), 64'(0));
        check("rst_addr", 64'(addr_o), 64'(0));
        check("rst_wdata", 64'(wdata_o), 64'(0));
        check("rst_core_reset", 64'(core_reset_o), 64'(1));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
    endtask

    task automatic check_status(input string tag);
        repeat (8) @(negedge clock);
        check({tag, "_done"}, 64'(done_o), 64'(m_done));
        check({tag, "_err"}, 64'(err_o), 64'(m_err));
        check({tag, "_core_reset"}, 64'(core_reset_o), 64'(!m_rel));
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == End) w = w ^ 32'h1;
        return w;
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && we_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write got addr=%0d data=%h required=no write",
                         addr_o, wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(addr_o), 64'(e.addr));
                check("write_data", 64'(wdata_o), 64'(e.data));
            end
        end
    end

    initial begin
        model_clear();

        // Directed three-word programme.
        do_reset();
        cpb = 16'd8;
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0001);
        finish_prog(1'b1);
        check_status("load3");
        check("load3_done_abs", 64'(done_o), 64'(1));
        check("load3_core_abs", 64'(core_reset_o), 64'(0));

        // Framing error on the second byte.
        do_reset();
        cpb = 16'd6;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        check_status("frame");
        check("frame_err_abs", 64'(err_o), 64'(1));
        finish_prog(1'b1);
        check_status("frame_end");

        // Overflow past the last address, then EndWord must be ignored.
        do_reset();
        cpb = 16'($urandom_range(4, 8));
        for (int i = 0; i < 5; i++) send_word(rand_word());
        check_status("ovf");
        check("ovf_err_abs", 64'(err_o), 64'(1));
        check("ovf_core_abs", 64'(core_reset_o), 64'(1));
        send_word(End);
        check_status("ovf_term");

        // Start-bit glitch.
        do_reset();
        cpb = 16'd16;
        @(negedge clock);
        rx = 1'b0;
        repeat (2) @(negedge clock);
        rx = 1'b1;
        repeat (200) @(negedge clock);
        check_status("glitch");
        send_word(rand_word());
        check_status("glitch_after");

        // Reset in the middle of a word.
        do_reset();
        cpb = 16'd5;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        do_reset();
        send_word(32'hCAFE_0123);
        check_status("midrst");

        // Random programmes, clean and (where meaningful) corrupted endings.
        for (int it = 0; it < 6; it++) begin
            int unsigned n;
            do_reset();
            cpb = 16'($urandom_range(4, 10));
            n = $urandom_range(0, 3);
            for (int k = 0; k < int'(n); k++) send_word(rand_word());
            finish_prog((it % 2) == 0);
            check_status("rand");
        end

`ifdef ICCM_BOOT_CHECKSUM_EN
        do_reset();
        cpb = 16'd8;
        send_word(32'h0F0F_0F0F);
        send_word(32'hF0F0_F0F0);
        send_word(End);
        send_word(32'hFFFF_FFFF);
        check_status("csum_ok");
        check("csum_ok_err_abs", 64'(err_o), 64'(0));
        do_reset();
        send_word(32'h0F0F_0F0F);
        send_word(32'hF0F0_F0F0);
        send_word(End);
        send_word(32'h0000_0000);
        check_status("csum_bad");
        check("csum_bad_core_abs", 64'(core_reset_o), 64'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
